// File: rtl/reaction_meter.sv
// reaction_meter: reaction-time game controller. Random pre-stimulus wait, then a
// 4-digit BCD millisecond counter until a press; tracks the best time since reset.
`default_nettype none

module reaction_meter #(
  parameter int MIN_DELAY = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_ms,
  input  logic        start,
  input  logic        button,
  input  logic [11:0] rnd,
  output logic        rnd_en,
  output logic        led,
  output logic        busy,
  output logic        result_valid,
  output logic        false_start,
  output logic        timeout,
  output logic [15:0] time_bcd,
  output logic [15:0] best_bcd
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    REACT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [11:0] MIN_DELAY_W = 12'(MIN_DELAY);
  localparam logic [15:0] BCD_MAX     = 16'h9999;

  state_t      state;
  state_t      state_next;
  logic        button_q;
  logic [11:0] wait_cnt;
  logic        press;

  logic        load_trial;
  logic        wait_dec;
  logic        time_inc;
  logic        end_valid;
  logic        end_false;
  logic        end_timeout;
  logic        best_load;

  // Decimal increment; digit 9 rolls to 0 and carries into the next digit.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign press = button & ~button_q;

  always_comb begin
    state_next  = state;
    load_trial  = 1'b0;
    wait_dec    = 1'b0;
    time_inc    = 1'b0;
    end_valid   = 1'b0;
    end_false   = 1'b0;
    end_timeout = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = WAIT;
          load_trial = 1'b1;
        end
      end
      WAIT: begin
        if (press) begin
          state_next = DONE;
          end_false  = 1'b1;
        end else if (tick_ms) begin
          if (wait_cnt <= 12'd1) begin
            state_next = REACT;
          end else begin
            wait_dec = 1'b1;
          end
        end
      end
      REACT: begin
        // A press freezes the count even if a tick lands in the same cycle.
        if (press) begin
          state_next = DONE;
          end_valid  = 1'b1;
        end else if (tick_ms) begin
          if (time_bcd == BCD_MAX) begin
            state_next  = DONE;
            end_timeout = 1'b1;
          end else begin
            time_inc = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // BCD digits compare correctly as plain unsigned binary.
  assign best_load = end_valid && (time_bcd != 16'h0000) &&
                     ((best_bcd == 16'h0000) || (time_bcd < best_bcd));

  assign rnd_en = load_trial & ~reset;
  assign led    = (state == REACT);
  assign busy   = (state == WAIT) || (state == REACT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      button_q     <= 1'b0;
      wait_cnt     <= 12'd0;
      time_bcd     <= 16'h0000;
      best_bcd     <= 16'h0000;
      result_valid <= 1'b0;
      false_start  <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      button_q <= button;
      if (load_trial) begin
        wait_cnt     <= MIN_DELAY_W + {2'b00, rnd[9:0]};
        time_bcd     <= 16'h0000;
        result_valid <= 1'b0;
        false_start  <= 1'b0;
        timeout      <= 1'b0;
      end
      if (wait_dec) begin
        wait_cnt <= wait_cnt - 12'd1;
      end
      if (time_inc) begin
        time_bcd <= bcd_inc(time_bcd);
      end
      if (end_false) begin
        false_start <= 1'b1;
        time_bcd    <= 16'h0000;
      end
      if (end_valid) begin
        result_valid <= 1'b1;
      end
      if (end_timeout) begin
        timeout <= 1'b1;
      end
      if (best_load) begin
        best_bcd <= time_bcd;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reaction_meter.sv
// Directed self-checking bench for reaction_meter (MIN_DELAY = 500).
`default_nettype none

module tb_reaction_meter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick_ms = 1'b0;
  logic        start = 1'b0;
  logic        button = 1'b0;
  logic [11:0] rnd = 12'h000;
  logic        rnd_en;
  logic        led;
  logic        busy;
  logic        result_valid;
  logic        false_start;
  logic        timeout;
  logic [15:0] time_bcd;
  logic [15:0] best_bcd;

  int passed = 0;
  int total  = 0;

  reaction_meter #(.MIN_DELAY(500)) dut (
    .clk(clk), .reset(reset), .tick_ms(tick_ms), .start(start),
    .button(button), .rnd(rnd), .rnd_en(rnd_en), .led(led), .busy(busy),
    .result_valid(result_valid), .false_start(false_start),
    .timeout(timeout), .time_bcd(time_bcd), .best_bcd(best_bcd)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    tick_ms = 1'b1;
    repeat (n) cycle();
    tick_ms = 1'b0;
  endtask

  // Starts a trial and runs the full wait; the caller knows the wait length.
  task automatic run_to_react(input logic [11:0] r, input int wait_ticks);
    rnd   = r;
    start = 1'b1;
    cycle();
    start = 1'b0;
    ticks(wait_ticks);
    total++;
    if (led !== 1'b1) $display("FAIL run_to_react_led got %0b want 1", led);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) cycle();
    reset = 1'b0;
    total++;
    if ({led, busy, rnd_en, result_valid, false_start, timeout} !== 6'b0)
      $display("FAIL reset_flags got %b want 000000",
               {led, busy, rnd_en, result_valid, false_start, timeout});
    else passed++;
    total++;
    if ({time_bcd, best_bcd} !== 32'h0)
      $display("FAIL reset_bcd got %h want 00000000", {time_bcd, best_bcd});
    else passed++;
  endtask

  task automatic test_first_trial();
    rnd   = 12'h0A5;
    start = 1'b1;
    #1;
    total++;
    if (rnd_en !== 1'b1) $display("FAIL start_rnd_en got %0b want 1", rnd_en);
    else passed++;
    cycle();
    start = 1'b0;
    #1;
    total++;
    if ({busy, led, rnd_en} !== 3'b100)
      $display("FAIL wait_entry got busy/led/rnd_en=%b want 100", {busy, led, rnd_en});
    else passed++;
    ticks(664);
    total++;
    if ({busy, led} !== 2'b10) $display("FAIL wait_664 got busy/led=%b want 10", {busy, led});
    else passed++;
    ticks(1);
    total++;
    if (led !== 1'b1) $display("FAIL react_665 got led=%0b want 1", led);
    else passed++;
    ticks(237);
    button = 1'b1;
    cycle();
    button = 1'b0;
    total++;
    if ({result_valid, led, busy} !== 3'b100 || time_bcd !== 16'h0237 || best_bcd !== 16'h0237)
      $display("FAIL trial1 got v/led/busy=%b time=%h best=%h want 100 0237 0237",
               {result_valid, led, busy}, time_bcd, best_bcd);
    else passed++;
    cycle();
  endtask

  task automatic test_best();
    run_to_react(12'h000, 500);
    ticks(412);
    button = 1'b1;
    cycle();
    button = 1'b0;
    total++;
    if (time_bcd !== 16'h0412 || best_bcd !== 16'h0237 || result_valid !== 1'b1)
      $display("FAIL trial2 got time=%h best=%h v=%0b want 0412 0237 1",
               time_bcd, best_bcd, result_valid);
    else passed++;
    cycle();
    run_to_react(12'h400, 500);  // rnd[9:0] = 0
    ticks(105);
    button = 1'b1;
    cycle();
    button = 1'b0;
    total++;
    if (time_bcd !== 16'h0105 || best_bcd !== 16'h0105)
      $display("FAIL trial3 got time=%h best=%h want 0105 0105", time_bcd, best_bcd);
    else passed++;
    cycle();
  endtask

  task automatic test_false_start();
    button = 1'b1;
    cycle();
    rnd   = 12'h000;
    start = 1'b1;
    cycle();
    start = 1'b0;
    total++;
    if ({busy, result_valid, time_bcd} !== {2'b10, 16'h0000})
      $display("FAIL fs_start got busy=%0b v=%0b time=%h want 1 0 0000",
               busy, result_valid, time_bcd);
    else passed++;
    ticks(299);
    total++;
    if ({busy, false_start} !== 2'b10)
      $display("FAIL fs_held got busy/fs=%b want 10", {busy, false_start});
    else passed++;
    button = 1'b0;
    cycle();
    button  = 1'b1;
    tick_ms = 1'b1;
    cycle();
    tick_ms = 1'b0;
    button  = 1'b0;
    total++;
    if ({false_start, result_valid, busy, led} !== 4'b1000 || time_bcd !== 16'h0000)
      $display("FAIL fs_done got fs/v/busy/led=%b time=%h want 1000 0000",
               {false_start, result_valid, busy, led}, time_bcd);
    else passed++;
    ticks(250);
    total++;
    if (led !== 1'b0 || best_bcd !== 16'h0105)
      $display("FAIL fs_after got led=%0b best=%h want 0 0105", led, best_bcd);
    else passed++;
  endtask

  task automatic test_press_with_tick();
    run_to_react(12'h000, 500);
    ticks(9);
    total++;
    if (time_bcd !== 16'h0009) $display("FAIL bcd_9 got %h want 0009", time_bcd);
    else passed++;
    ticks(1);
    total++;
    if (time_bcd !== 16'h0010) $display("FAIL carry_10 got %h want 0010", time_bcd);
    else passed++;
    ticks(89);
    button  = 1'b1;
    tick_ms = 1'b1;
    cycle();
    tick_ms = 1'b0;
    button  = 1'b0;
    total++;
    if (time_bcd !== 16'h0099 || result_valid !== 1'b1 || best_bcd !== 16'h0099)
      $display("FAIL press_tick got time=%h v=%0b best=%h want 0099 1 0099",
               time_bcd, result_valid, best_bcd);
    else passed++;
    cycle();
  endtask

  task automatic test_timeout();
    run_to_react(12'h000, 500);
    ticks(99);
    ticks(1);
    total++;
    if (time_bcd !== 16'h0100) $display("FAIL carry_100 got %h want 0100", time_bcd);
    else passed++;
    ticks(899);
    ticks(1);
    total++;
    if (time_bcd !== 16'h1000) $display("FAIL carry_1000 got %h want 1000", time_bcd);
    else passed++;
    ticks(8999);
    total++;
    if (time_bcd !== 16'h9999 || timeout !== 1'b0 || busy !== 1'b1)
      $display("FAIL at_9999 got time=%h to=%0b busy=%0b want 9999 0 1",
               time_bcd, timeout, busy);
    else passed++;
    ticks(1);
    total++;
    if ({timeout, busy, led, result_valid} !== 4'b1000 || time_bcd !== 16'h9999 ||
        best_bcd !== 16'h0099)
      $display("FAIL timeout got to/busy/led/v=%b time=%h best=%h want 1000 9999 0099",
               {timeout, busy, led, result_valid}, time_bcd, best_bcd);
    else passed++;
    ticks(3);
    total++;
    if (timeout !== 1'b1 || time_bcd !== 16'h9999)
      $display("FAIL done_hold got to=%0b time=%h want 1 9999", timeout, time_bcd);
    else passed++;
  endtask

  task automatic test_zero_result();
    run_to_react(12'h000, 500);
    button = 1'b1;
    cycle();
    button = 1'b0;
    total++;
    if (result_valid !== 1'b1 || time_bcd !== 16'h0000 || best_bcd !== 16'h0099)
      $display("FAIL zero_result got v=%0b time=%h best=%h want 1 0000 0099",
               result_valid, time_bcd, best_bcd);
    else passed++;
    cycle();
  endtask

  task automatic test_reset_midtrial();
    run_to_react(12'h000, 500);
    ticks(50);
    total++;
    if (time_bcd !== 16'h0050) $display("FAIL pre_reset got %h want 0050", time_bcd);
    else passed++;
    reset = 1'b1;
    start = 1'b1;
    #1;
    total++;
    if (rnd_en !== 1'b0) $display("FAIL reset_rnd_en got %0b want 0", rnd_en);
    else passed++;
    cycle();
    start = 1'b0;
    reset = 1'b0;
    total++;
    if ({led, busy, result_valid, false_start, timeout} !== 5'b0 ||
        time_bcd !== 16'h0000 || best_bcd !== 16'h0000)
      $display("FAIL reset_mid got flags=%b time=%h best=%h want 00000 0000 0000",
               {led, busy, result_valid, false_start, timeout}, time_bcd, best_bcd);
    else passed++;
  endtask

  task automatic test_start_ignored();
    rnd   = 12'h000;
    start = 1'b1;
    cycle();
    start = 1'b0;
    ticks(100);
    rnd   = 12'h3FF;
    start = 1'b1;
    #1;
    total++;
    if (rnd_en !== 1'b0) $display("FAIL ignored_rnd_en got %0b want 0", rnd_en);
    else passed++;
    cycle();
    start = 1'b0;
    ticks(399);
    total++;
    if ({busy, led} !== 2'b10) $display("FAIL ignored_wait got busy/led=%b want 10", {busy, led});
    else passed++;
    ticks(1);
    total++;
    if (led !== 1'b1) $display("FAIL ignored_react got led=%0b want 1", led);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_first_trial();
    test_best();
    test_false_start();
    test_press_with_tick();
    test_timeout();
    test_zero_result();
    test_reset_midtrial();
    test_start_ignored();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
